src_arbiter: RTL
================

SRC_ARBITER -- requirements
Module: src_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 4, gives the maximum number of beats transferred per grant; legal range 1..8.
REQ-002 clk  input  1  Single clock; all state changes on the rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 req  input  8  Per-source request; bit i asks for the mux input i to be routed downstream.
REQ-005 ready  input  1  Downstream accepts the current beat.
REQ-006 sel  output  3  Registered control for the 8:1 16-bit mux; the value equals the granted index.
REQ-007 grant  output  8  Registered one-hot grant; bit sel is set while BUSY; all zeros in IDLE.
REQ-008 valid  output  1  The beat on the mux output is valid; high exactly when BUSY.
REQ-009 last  output  1  Combinational; high when valid and the current beat is the final beat of this grant.

Function
REQ-010 The FSM SHALL have two states: IDLE and BUSY.
REQ-011 Arbitration SHALL be round-robin: search begins at index (ptr+1) mod 8 and wraps upward; the first set req bit wins.
REQ-012 The 3-bit pointer ptr SHALL load the winning index on every grant.
REQ-013 In IDLE with any req bit set, the FSM SHALL enter BUSY next cycle with sel, grant, ptr set to the winner; latency from req to valid is 1 cycle.
REQ-014 In IDLE with req==0, all outputs SHALL hold their idle values: valid=0, grant=0, sel unchanged.
REQ-015 A transfer occurs on a cycle with valid&&ready; sel and grant SHALL remain stable from valid rise until the transfer.
REQ-016 A 3-bit beat counter SHALL clear on grant and increment on each transfer.
REQ-017 last SHALL be 1 when valid and either beat==HOLD_MAX-1 or req[sel]==0.
REQ-018 On a transfer with last=0, the FSM SHALL stay BUSY with the same grant.
REQ-019 On a transfer with last=1 and another eligible req set, the FSM SHALL re-arbitrate in the same cycle and enter BUSY with the new winner (no idle bubble); the departing index is eligible only if no other bit is set.
REQ-020 On a transfer with last=1 and no eligible req, the FSM SHALL return to IDLE.
REQ-021 If req[sel] drops while valid&&!ready, valid SHALL stay high until the beat is taken; that beat is last.
REQ-022 Changes on req bits other than sel SHALL NOT affect a BUSY grant before its release.

Reset
REQ-023 While rst is high at a clock edge, the FSM SHALL enter IDLE with sel=0, grant=0, valid=0, beat=0, ptr=7, so index 0 is searched first.
REQ-024 Reset asserted mid-grant SHALL abort the grant without a transfer; valid SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-025 Macro SRC_ARBITER_PRIO0_EN: when defined, req[0] SHALL win every arbitration regardless of ptr, and ptr SHALL be unchanged by a grant to index 0.
REQ-026 When SRC_ARBITER_PRIO0_EN is undefined, index 0 SHALL be treated as an ordinary round-robin source.

Verification
REQ-027 Apply rst, then req=8'h00 for 3 cycles -> valid=0, grant=8'h00, sel=0 throughout.
REQ-028 From reset, req=8'h81 held with ready=1 and HOLD_MAX=4 -> source 0 gets 4 beats (last on the 4th), then source 7 gets 4 beats, then source 0 again, with no gap cycles.
REQ-029 Grant to source 2 with ready=0 for 5 cycles, then req[2] drops while ready=0 -> sel=2 and valid=1 are stable; the first ready=1 cycle takes a beat with last=1; the FSM then goes to IDLE.
REQ-030 Grant to source 5 mid-beat 2, then pulse rst -> next cycle valid=0, grant=0, ptr=7; req=8'h20 then gives grant=8'h20 after 1 cycle.
REQ-031 With SRC_ARBITER_PRIO0_EN defined, req=8'h07 held with ready=1 -> source 0 is regranted after each HOLD_MAX release; sources 1 and 2 are never granted. Without the macro -> grant order is 0, 1, 2, 0.
REQ-032 With HOLD_MAX=1 and req=8'hFF, ready=1 -> one beat per grant; sel steps 0,1,...,7,0 and last=1 every cycle.

Source files
------------

// File: rtl/src_arbiter.sv
// src_arbiter: 8-source round-robin arbiter driving the select of an 8:1
// 16-bit mux. A grant lasts up to HOLD_MAX beats, or ends early when the
// owner drops its request. On release the next winner is granted in the
// same cycle, so there is no idle bubble.
//
// Optional feature: define SRC_ARBITER_PRIO0_EN to give source 0 absolute
// priority. A grant to source 0 then leaves the round-robin pointer untouched.
//
// Handshake: valid is high exactly while BUSY. A beat transfers on a cycle
// with valid && ready. sel and grant stay stable from the rise of valid until
// the final transfer of the grant. last is combinational and marks the beat
// that ends the grant.
module src_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       ready,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       valid,
  output logic       last,
  output logic [0:0] o_dbg_state,
  output logic [2:0] o_dbg_ptr,
  output logic [2:0] o_dbg_beat
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_BUSY   = 1'b1;
  localparam logic [2:0] LAST_BEAT = 3'(HOLD_MAX - 1);

  logic [0:0] r_state;
  logic [2:0] r_sel;
  logic [7:0] r_grant;
  logic [2:0] r_ptr;
  logic [2:0] r_beat;

  logic [2:0] w_win;
  logic       w_found;
  logic       w_any;
  logic       w_valid;
  logic       w_last;
  logic       w_xfer;
  logic [2:0] w_next_ptr;

  // Round-robin search starting one above the pointer. The last-granted index
  // is visited last, so it only wins again when nothing else is requesting.
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      logic [2:0] v_idx;
      v_idx = r_ptr + 3'(i);
      if (!w_found && req[v_idx]) begin
        w_win   = v_idx;
        w_found = 1'b1;
      end
    end
`ifdef SRC_ARBITER_PRIO0_EN
    if (req[0]) begin
      w_win = 3'd0;
    end
`endif
  end

  // Pointer update on grant; a priority grant to source 0 leaves it unchanged.
  always_comb begin
`ifdef SRC_ARBITER_PRIO0_EN
    w_next_ptr = (w_win == 3'd0) ? r_ptr : w_win;
`else
    w_next_ptr = w_win;
`endif
  end

  // Handshake and release conditions.
  always_comb begin
    w_any   = |req;
    w_valid = (r_state == ST_BUSY);
    w_last  = w_valid && ((r_beat == LAST_BEAT) || !req[r_sel]);
    w_xfer  = w_valid && ready;
  end

  // Grant FSM: IDLE waits for any request; BUSY counts beats until release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 3'd0;
      r_grant <= 8'h00;
      r_ptr   <= 3'd7;
      r_beat  <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_BUSY;
            r_sel   <= w_win;
            r_grant <= 8'b1 << w_win;
            r_ptr   <= w_next_ptr;
            r_beat  <= 3'd0;
          end
        end
        default: begin
          if (w_xfer) begin
            if (!w_last) begin
              r_beat <= r_beat + 3'd1;
            end else if (w_any) begin
              r_state <= ST_BUSY;
              r_sel   <= w_win;
              r_grant <= 8'b1 << w_win;
              r_ptr   <= w_next_ptr;
              r_beat  <= 3'd0;
            end else begin
              r_state <= ST_IDLE;
              r_grant <= 8'h00;
            end
          end
        end
      endcase
    end
  end

  assign sel         = r_sel;
  assign grant       = r_grant;
  assign valid       = w_valid;
  assign last        = w_last;
  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;
  assign o_dbg_beat  = r_beat;

endmodule
